keypad_matrix_entry: RTL and testbench
======================================

// Module: keypad_matrix_entry
// PURPOSE
//  Turns 4-bit keypad codes from the keypad Decoder into a packed matrix of NUM_ELEMS unsigned decimal values.
//  Debounces each key, accumulates multi-digit numbers and commits them on ENTER (4'hE).
//  Raises matrix_valid on DONE (4'hD) and holds it until matrix_ack.
//  Sits between the keypad Decoder and the regression datapath; acc_out/elem_idx also feed the OLED color_gen.
// PARAMETERS
//  ELEM_WIDTH      12  bits per element (unsigned; signed when KEYPAD_SIGNED_EN is defined)
//  NUM_ELEMS       6   elements per matrix (NUM_SAMPLES*NUM_FEATURES)
//  DEBOUNCE_CYCLES 16  consecutive stable cycles needed to accept a press or a release (>=2)
// PORTS
//  clock          in   1                     system clock
//  reset          in   1                     asynchronous, active-high
//  key_code       in   4                     decoded key (0-9 digit, A bksp, B clr/sign, C rsvd, D done, E enter, F none)
//  key_press      in   1                     level, high while any key is held
//  matrix_ack     in   1                     consumer has taken matrix_out
//  matrix_out     out  NUM_ELEMS*ELEM_WIDTH  element k at [k*ELEM_WIDTH +: ELEM_WIDTH]
//  acc_out        out  ELEM_WIDTH            value currently being typed
//  elem_idx       out  $clog2(NUM_ELEMS+1)   number of committed elements
//  ready_input    out  1                     high in ENTRY state
//  matrix_valid   out  1                     high in DONE state
//  overflow       out  1                     sticky: current entry saturated
//  key_event      out  1                     1-cycle pulse per accepted key
//  key_event_code out  4                     code of last accepted key
// BEHAVIOUR
//  Reset: all outputs 0, state ENTRY (ready_input=1 one cycle after reset release), debounce idle.
//  Debounce: counter restarts whenever key_code changes or key_press=0.
//  - Event: key_press=1 with a stable code for DEBOUNCE_CYCLES cycles -> key_event high in the next cycle.
//  - Latch-out: no further event until key_press=0 for DEBOUNCE_CYCLES consecutive cycles; holding a key gives one event.
//  Key actions take effect on the key_event cycle; results are visible in the next cycle.
//  - digit d (ENTRY): acc = acc*10+d, computed in ELEM_WIDTH+4 bits.
//    If the result exceeds MAX (2^ELEM_WIDTH-1): acc=MAX and overflow=1.
//  - A (ENTRY): acc = acc/10; overflow cleared.
//  - B (ENTRY): acc=0, overflow=0.
//  - E (ENTRY): slot[elem_idx]=acc, elem_idx++, acc=0, overflow=0.
//    If elem_idx reaches NUM_ELEMS -> FULL.
//  - D (ENTRY or FULL): -> DONE. Uncommitted acc is discarded; unfilled slots read 0.
//  - C, F: ignored in every state (key_event still pulses).
//  FSM: ENTRY --E,last slot--> FULL; ENTRY/FULL --D--> DONE; DONE --matrix_ack--> ENTRY.
//  - FULL: digits, A, B and E are ignored; only D advances.
//  - Leaving DONE: elem_idx=0, acc=0, matrix_out cleared to 0 in the cycle after ack.
//  - DONE: every key is ignored; matrix_out is frozen.
//  Simultaneous events:
//  - matrix_ack in ENTRY/FULL: ignored.
//  - matrix_ack and key_event in the same DONE cycle: ack wins and the key is dropped.
//  Reset asserted mid-entry or mid-debounce: immediate clear; no partial commit.
// CONFIGURATION
//  KEYPAD_SIGNED_EN defined:
//  - B toggles a sign flag instead of clearing; MAX = 2^(ELEM_WIDTH-1)-1.
//  - E commits the two's complement when the sign is set; the sign clears on E/A-to-zero/ack.
//  - acc_out shows the signed value.
//  KEYPAD_SIGNED_EN undefined: unsigned only, B = clear, MAX = 2^ELEM_WIDTH-1.
// TESTING
//  1. Press 1,2,E with DEBOUNCE_CYCLES=4 -> three key_event pulses; slot0=12, elem_idx=1, acc_out=0.
//  2. Hold digit 7 for 100 cycles with a 2-cycle glitch to 4'h3 mid-press -> exactly one event (7); acc=7.
//  3. Type 9,9,9,9,9 (W=12) -> acc=4095, overflow=1. Then A -> acc=409, overflow=0.
//  4. Enter 6 values 1..6 with E -> FULL, ready_input=0. Then digit 5 is ignored.
//     Then D -> matrix_valid=1, matrix_out=={12'd6,..,12'd1}.
//  5. In DONE, assert matrix_ack in the same cycle as a D event -> next cycle ENTRY, elem_idx=0, matrix_out=0.
//  6. Assert reset after 3 digits -> acc_out=0, elem_idx=0, ready_input=1 after release.
//     SIGNED_EN: B,2,5,E -> slot0=12'hFE7 (-25).

Source files
------------

// File: rtl/keypad_matrix_entry.sv
// keypad_matrix_entry
//   Turns 4-bit keypad codes into a packed matrix of NUM_ELEMS decimal values.
//   Each key is debounced on press and on release. Digits build up a
//   multi-digit number that saturates at MAX. ENTER (E) commits that number
//   into the next slot. DONE (D) raises matrix_valid, which stays high until
//   matrix_ack.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   key_code[3:0]       decoded key (0-9 digit, A bksp, B clr/sign, C rsvd,
//                       D done, E enter, F none)
//   key_press           level, high while any key is held
//   matrix_ack          consumer has taken matrix_out
//   matrix_out          element k at [k*ELEM_WIDTH +: ELEM_WIDTH]
//   acc_out             value currently being typed
//   elem_idx            number of committed elements
//   ready_input         high in ENTRY state
//   matrix_valid        high in DONE state
//   overflow            sticky flag: the current entry saturated
//   key_event           one-cycle pulse per accepted key
//   key_event_code      code of the last accepted key
//
// Build option
//   KEYPAD_SIGNED_EN    B toggles a sign flag and MAX = 2^(ELEM_WIDTH-1)-1.
//                       ENTER commits the two's complement when the sign is set.
//                       Without this macro, values are unsigned and B clears.

module keypad_matrix_entry #(
    parameter int ELEM_WIDTH      = 12,
    parameter int NUM_ELEMS       = 6,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [3:0]                      key_code,
    input  logic                            key_press,
    input  logic                            matrix_ack,
    output logic [NUM_ELEMS*ELEM_WIDTH-1:0] matrix_out,
    output logic [ELEM_WIDTH-1:0]           acc_out,
    output logic [$clog2(NUM_ELEMS+1)-1:0]  elem_idx,
    output logic                            ready_input,
    output logic                            matrix_valid,
    output logic                            overflow,
    output logic                            key_event,
    output logic [3:0]                      key_event_code
);

    localparam int IDX_W = $clog2(NUM_ELEMS + 1);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEMS - 1);
    localparam logic [ELEM_WIDTH+3:0] TEN_W = (ELEM_WIDTH + 4)'(10);
    localparam logic [ELEM_WIDTH-1:0] TEN_E = ELEM_WIDTH'(10);
`ifdef KEYPAD_SIGNED_EN
    localparam logic [ELEM_WIDTH+3:0] MAX_W = {5'd0, {(ELEM_WIDTH-1){1'b1}}};
`else
    localparam logic [ELEM_WIDTH+3:0] MAX_W = {4'd0, {ELEM_WIDTH{1'b1}}};
`endif

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_CLR   = 4'hB;
    localparam logic [3:0] KEY_DONE  = 4'hD;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    typedef enum logic [1:0] {ST_ENTRY, ST_FULL, ST_DONE} state_t;

    // Appends one decimal digit with 4 bits of headroom.
    // The result is {saturated, value}.
    function automatic logic [ELEM_WIDTH:0] sat_digit(input logic [ELEM_WIDTH-1:0] a,
                                                      input logic [3:0] d);
        logic [ELEM_WIDTH+3:0] wide;
        wide = ({4'd0, a} * TEN_W) + {{ELEM_WIDTH{1'b0}}, d};
        if (wide > MAX_W)
            return {1'b1, MAX_W[ELEM_WIDTH-1:0]};
        return {1'b0, wide[ELEM_WIDTH-1:0]};
    endfunction

    logic [CNT_W-1:0]      db_cnt;
    logic [3:0]            db_code;
    logic                  db_latched;
    logic                  fire_p0;
    logic                  vld_p1;
    logic [3:0]            code_p1;
    state_t                state_q, state_d;
    logic                  ready_d, valid_d;
    logic [ELEM_WIDTH-1:0] acc_q;
    logic                  ovf_q;
    logic [ELEM_WIDTH:0]   digit_sat;
    logic [ELEM_WIDTH-1:0] commit_val;
    logic                  is_digit;

    // Stage 0: debounce. The same counter times a stable press while armed
    // and a clean release while latched.
    assign fire_p0 = !db_latched && key_press && (key_code == db_code) && (db_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt     <= '0;
            db_code    <= '0;
            db_latched <= 1'b0;
            vld_p1     <= 1'b0;
            code_p1    <= '0;
        end else begin
            db_code <= key_code;
            vld_p1  <= fire_p0;
            if (fire_p0)
                code_p1 <= key_code;
            if (!db_latched) begin
                if (!key_press)
                    db_cnt <= '0;
                else if (fire_p0) begin
                    db_cnt     <= '0;
                    db_latched <= 1'b1;
                end else if (db_cnt != '0 && key_code == db_code)
                    db_cnt <= db_cnt + CNT_W'(1);
                else
                    db_cnt <= CNT_W'(1);
            end else begin
                if (key_press)
                    db_cnt <= '0;
                else if (db_cnt == CNT_LAST) begin
                    db_cnt     <= '0;
                    db_latched <= 1'b0;
                end else
                    db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1: the accepted key acts on the FSM and on the datapath.
    assign key_event      = vld_p1;
    assign key_event_code = code_p1;
    assign is_digit       = (code_p1 <= 4'd9);
    assign digit_sat      = sat_digit(acc_q, code_p1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ENTRY;
            ready_input  <= 1'b0;
            matrix_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_input  <= ready_d;
            matrix_valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTRY: begin
                if (vld_p1) begin
                    if (code_p1 == KEY_DONE)
                        state_d = ST_DONE;
                    else if (code_p1 == KEY_ENTER && elem_idx == IDX_LAST)
                        state_d = ST_FULL;
                end
            end
            ST_FULL:  if (vld_p1 && code_p1 == KEY_DONE) state_d = ST_DONE;
            ST_DONE:  if (matrix_ack) state_d = ST_ENTRY;
            default:  state_d = ST_ENTRY;
        endcase
    end

    // The status flags are registered from the next state.
    // This keeps them low while reset is held.
    always_comb begin
        ready_d = (state_d == ST_ENTRY);
        valid_d = (state_d == ST_DONE);
    end

`ifdef KEYPAD_SIGNED_EN
    logic sign_q;
    assign commit_val = sign_q ? (~acc_q + ELEM_WIDTH'(1)) : acc_q;
`else
    assign commit_val = acc_q;
`endif
    assign acc_out  = commit_val;
    assign overflow = ovf_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            elem_idx   <= '0;
            matrix_out <= '0;
`ifdef KEYPAD_SIGNED_EN
            sign_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (vld_p1) begin
                        if (is_digit) begin
                            acc_q <= digit_sat[ELEM_WIDTH-1:0];
                            ovf_q <= ovf_q | digit_sat[ELEM_WIDTH];
                        end else begin
                            case (code_p1)
                                KEY_BKSP: begin
                                    acc_q <= acc_q / TEN_E;
                                    ovf_q <= 1'b0;
`ifdef KEYPAD_SIGNED_EN
                                    if (acc_q < TEN_E) sign_q <= 1'b0;
`endif
                                end
                                KEY_CLR: begin
`ifdef KEYPAD_SIGNED_EN
                                    sign_q <= ~sign_q;
`else
                                    acc_q <= '0;
                                    ovf_q <= 1'b0;
`endif
                                end
                                KEY_ENTER: begin
                                    for (int k = 0; k < NUM_ELEMS; k++)
                                        if (IDX_W'(k) == elem_idx)
                                            matrix_out[k*ELEM_WIDTH +: ELEM_WIDTH] <= commit_val;
                                    elem_idx <= elem_idx + IDX_W'(1);
                                    acc_q    <= '0;
                                    ovf_q    <= 1'b0;
`ifdef KEYPAD_SIGNED_EN
                                    sign_q   <= 1'b0;
`endif
                                end
                                KEY_DONE: begin
                                    // Any half-typed value is dropped.
                                    acc_q  <= '0;
                                    ovf_q  <= 1'b0;
`ifdef KEYPAD_SIGNED_EN
                                    sign_q <= 1'b0;
`endif
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_DONE: begin
                    if (matrix_ack) begin
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        elem_idx   <= '0;
                        matrix_out <= '0;
`ifdef KEYPAD_SIGNED_EN
                        sign_q     <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_matrix_entry.sv
module tb_keypad_matrix_entry;

    localparam int W   = 12;
    localparam int N   = 6;
    localparam int DB  = 4;
    localparam int MAX = 4095;

    logic           clock = 1'b0;
    logic           reset;
    logic [3:0]     key_code;
    logic           key_press;
    logic           matrix_ack;
    logic [N*W-1:0] matrix_out;
    logic [W-1:0]   acc_out;
    logic [2:0]     elem_idx;
    logic           ready_input;
    logic           matrix_valid;
    logic           overflow;
    logic           key_event;
    logic [3:0]     key_event_code;

    always #5 clock = ~clock;

    keypad_matrix_entry #(
        .ELEM_WIDTH(W), .NUM_ELEMS(N), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clock), .reset(reset), .key_code(key_code), .key_press(key_press),
        .matrix_ack(matrix_ack), .matrix_out(matrix_out), .acc_out(acc_out),
        .elem_idx(elem_idx), .ready_input(ready_input), .matrix_valid(matrix_valid),
        .overflow(overflow), .key_event(key_event), .key_event_code(key_event_code)
    );

    int checks = 0;
    int errors = 0;
    int ev_seen = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference model. The debounce part looks back over the
    // recent press history. The key actions use plain integer arithmetic.
    bit         hist_press[$];
    logic [3:0] hist_code[$];
    bit         armed;
    bit         m_ev;
    logic [3:0] m_ev_code;
    int         m_state;   // 0 entry, 1 full, 2 done
    int         m_acc;
    bit         m_ovf;
    int         m_cnt;
    int         m_slot[N];
    bit         m_ready;
    bit         m_valid;

    task automatic model_reset();
        hist_press.delete();
        hist_code.delete();
        armed = 1; m_ev = 0; m_ev_code = 4'h0;
        m_state = 0; m_acc = 0; m_ovf = 0; m_cnt = 0;
        for (int k = 0; k < N; k++) m_slot[k] = 0;
        m_ready = 0; m_valid = 0;
    endtask

    function automatic logic [N*W-1:0] pack_slots();
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(m_slot[k]);
        return r;
    endfunction

    task automatic model_step();
        int  v;
        int  t;
        bit  ok;
        bit  fire;
        // The key shown this cycle acts on the state.
        if (m_state == 2) begin
            if (matrix_ack) begin
                m_state = 0; m_acc = 0; m_ovf = 0; m_cnt = 0;
                for (int k = 0; k < N; k++) m_slot[k] = 0;
            end
        end else if (m_ev) begin
            if (m_ev_code == 4'hD) begin
                m_state = 2; m_acc = 0; m_ovf = 0;
            end else if (m_state == 0) begin
                if (m_ev_code <= 4'd9) begin
                    v = m_acc * 10 + int'(m_ev_code);
                    if (v > MAX) begin m_acc = MAX; m_ovf = 1; end
                    else m_acc = v;
                end else if (m_ev_code == 4'hA) begin
                    m_acc = m_acc / 10; m_ovf = 0;
                end else if (m_ev_code == 4'hB) begin
                    m_acc = 0; m_ovf = 0;
                end else if (m_ev_code == 4'hE) begin
                    m_slot[m_cnt] = m_acc; m_cnt++; m_acc = 0; m_ovf = 0;
                    if (m_cnt == N) m_state = 1;
                end
            end
        end
        m_ready = (m_state == 0);
        m_valid = (m_state == 2);
        // Debounce: a press is accepted when the last DB samples show the same
        // held code. After that, the last DB samples must all be released.
        hist_press.push_back(key_press);
        hist_code.push_back(key_code);
        if (hist_press.size() > DB) begin
            void'(hist_press.pop_front());
            void'(hist_code.pop_front());
        end
        t = hist_press.size() - 1;
        fire = 0;
        if (t == DB - 1) begin
            if (armed) begin
                ok = 1;
                for (int i = 0; i < DB; i++)
                    if (!hist_press[i] || hist_code[i] != hist_code[t]) ok = 0;
                fire = ok;
            end else begin
                ok = 1;
                for (int i = 0; i < DB; i++)
                    if (hist_press[i]) ok = 0;
                if (ok) armed = 1;
            end
        end
        if (fire) begin
            armed = 0;
            m_ev_code = hist_code[t];
        end
        m_ev = fire;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        if (key_event) ev_seen++;
        check_val("key_event", 128'(key_event), 128'(m_ev));
        check_val("key_event_code", 128'(key_event_code), 128'(m_ev_code));
        check_val("acc_out", 128'(acc_out), 128'(m_acc));
        check_val("elem_idx", 128'(elem_idx), 128'(m_cnt));
        check_val("ready_input", 128'(ready_input), 128'(m_ready));
        check_val("matrix_valid", 128'(matrix_valid), 128'(m_valid));
        check_val("overflow", 128'(overflow), 128'(m_ovf));
        check_val("matrix_out", 128'(matrix_out), 128'(pack_slots()));
    endtask

    task automatic press_key(input logic [3:0] c);
        key_press = 1'b1; key_code = c;
        repeat (DB + 1) tick();
        key_press = 1'b0; key_code = 4'hF;
        repeat (DB + 1) tick();
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #2;
        check_val({tag, "_acc"}, 128'(acc_out), 128'(0));
        check_val({tag, "_idx"}, 128'(elem_idx), 128'(0));
        check_val({tag, "_ready"}, 128'(ready_input), 128'(0));
        check_val({tag, "_valid"}, 128'(matrix_valid), 128'(0));
        check_val({tag, "_ovf"}, 128'(overflow), 128'(0));
        check_val({tag, "_event"}, 128'(key_event), 128'(0));
        check_val({tag, "_code"}, 128'(key_event_code), 128'(0));
        check_val({tag, "_matrix"}, 128'(matrix_out), 128'(0));
        model_reset();
        reset = 1'b0;
    endtask

    function automatic logic [3:0] pick_code();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 55) return 4'($urandom_range(0, 9));
        if (r < 72) return 4'hE;
        if (r < 78) return 4'hA;
        if (r < 83) return 4'hB;
        if (r < 90) return 4'hD;
        return 4'($urandom_range(10, 15));
    endfunction

    task automatic rand_ack();
        if (m_state == 2) matrix_ack = ($urandom_range(0, 3) == 0);
        else matrix_ack = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        logic [N*W-1:0] exp_m;
        logic [3:0]     c;
        int             hold, gl, rel, ev0;

        reset = 1'b1; key_press = 1'b0; key_code = 4'hF; matrix_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        apply_reset("reset");
        tick();
        check_val("ready_after_reset", 128'(ready_input), 128'(1));

        // Typing 1, 2 and E commits 12 into slot 0.
        ev0 = ev_seen;
        press_key(4'd1); press_key(4'd2); press_key(4'hE);
        check_val("t1_events", 128'(ev_seen - ev0), 128'(3));
        check_val("t1_slot0", 128'(matrix_out[W-1:0]), 128'(12));
        check_val("t1_idx", 128'(elem_idx), 128'(1));
        check_val("t1_acc", 128'(acc_out), 128'(0));

        // Holding 7 with a short glitch gives a single event.
        ev0 = ev_seen;
        key_press = 1'b1;
        for (int i = 0; i < 100; i++) begin
            key_code = (i == 50 || i == 51) ? 4'h3 : 4'h7;
            tick();
        end
        key_press = 1'b0; key_code = 4'hF;
        repeat (DB + 1) tick();
        check_val("t2_events", 128'(ev_seen - ev0), 128'(1));
        check_val("t2_acc", 128'(acc_out), 128'(7));

        // The entry saturates, then backspace trims it.
        press_key(4'hB);
        repeat (5) press_key(4'd9);
        check_val("t3_acc_sat", 128'(acc_out), 128'(4095));
        check_val("t3_ovf", 128'(overflow), 128'(1));
        press_key(4'hA);
        check_val("t3_acc_bksp", 128'(acc_out), 128'(409));
        check_val("t3_ovf_clr", 128'(overflow), 128'(0));
        press_key(4'hB);

        // Reset in the middle of an entry.
        press_key(4'd3); press_key(4'd1); press_key(4'd4);
        apply_reset("midreset");
        tick();
        check_val("t6_ready", 128'(ready_input), 128'(1));
        check_val("t6_acc", 128'(acc_out), 128'(0));

        // Fill all slots with 1..6, then press D.
        for (int v = 1; v <= N; v++) begin
            press_key(4'(v));
            press_key(4'hE);
        end
        check_val("t4_idx", 128'(elem_idx), 128'(N));
        check_val("t4_ready", 128'(ready_input), 128'(0));
        press_key(4'd5);
        check_val("t4_full_digit", 128'(acc_out), 128'(0));
        press_key(4'hD);
        check_val("t4_valid", 128'(matrix_valid), 128'(1));
        exp_m = '0;
        for (int k = 0; k < N; k++) exp_m[k*W +: W] = W'(k + 1);
        check_val("t4_matrix", 128'(matrix_out), 128'(exp_m));

        // In DONE, ack arrives on the same cycle as a D event.
        key_press = 1'b1; key_code = 4'hD;
        repeat (DB + 1) begin
            tick();
            matrix_ack = m_ev;
        end
        check_val("t5_valid", 128'(matrix_valid), 128'(0));
        check_val("t5_ready", 128'(ready_input), 128'(1));
        check_val("t5_idx", 128'(elem_idx), 128'(0));
        check_val("t5_matrix", 128'(matrix_out), 128'(0));
        matrix_ack = 1'b0;
        key_press = 1'b0; key_code = 4'hF;
        repeat (DB + 1) tick();

        // Random presses with varied timing, glitches and acks.
        for (int it = 0; it < 300; it++) begin
            c    = pick_code();
            hold = int'($urandom_range(1, 2 * DB + 2));
            gl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, hold - 1)) : -10;
            rel  = int'($urandom_range(1, 2 * DB));
            key_press = 1'b1;
            for (int i = 0; i < hold; i++) begin
                key_code = (i == gl || i == gl + 1) ? (c ^ 4'h1) : c;
                rand_ack();
                tick();
            end
            key_press = 1'b0; key_code = 4'hF;
            for (int i = 0; i < rel; i++) begin
                rand_ack();
                tick();
            end
        end
        matrix_ack = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
